seq_sender: RTL

SEQ_SENDER -- requirements
Module: seq_sender

---
 rtl/seq_sender.sv | 125 ++++++++++++
 1 files changed

// File: rtl/seq_sender.sv
// Burst generator for the 01-10-11 sequence detector: emits `rep` triplets
// separated by `gap` idle symbols, then a one-cycle done pulse.
module seq_sender #(
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [REP_W-1:0] rep,
  input  logic [1:0]       gap,
  output logic [1:0]       num,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] sent
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    GAP  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [REP_W-1:0] rem_q, rem_d;
  logic [REP_W-1:0] sent_q, sent_d;
  logic [1:0]       gap_lat_q, gap_lat_d;
  logic [1:0]       gcnt_q, gcnt_d;
  logic [1:0]       num_q, num_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      sent_q    <= '0;
      gap_lat_q <= '0;
      gcnt_q    <= '0;
      num_q     <= 2'b00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      sent_q    <= sent_d;
      gap_lat_q <= gap_lat_d;
      gcnt_q    <= gcnt_d;
      num_q     <= num_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // rem_q counts triplets still to send, including the one in flight.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    sent_d    = sent_q;
    gap_lat_d = gap_lat_q;
    gcnt_d    = gcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d     = rep;
          gap_lat_d = gap;
          sent_d    = '0;
          state_d   = (rep != '0) ? S1 : DONE;
        end
      end
      S1: state_d = S2;
      S2: state_d = S3;
      S3: begin
        sent_d = sent_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_q == REP_W'(1)) begin
          state_d = DONE;
        end else if (gap_lat_q != 2'd0) begin
          state_d = GAP;
          gcnt_d  = gap_lat_q;
        end else begin
          state_d = S1;
        end
      end
      GAP: begin
        if (gcnt_q <= 2'd1) begin
          state_d = S1;
        end else begin
          gcnt_d = gcnt_q - 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops.
  always_comb begin
    num_d   = 2'b00;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S1:      begin num_d = 2'b01; valid_d = 1'b1; busy_d = 1'b1; end
      S2:      begin num_d = 2'b10; valid_d = 1'b1; busy_d = 1'b1; end
      S3:      begin num_d = 2'b11; valid_d = 1'b1; busy_d = 1'b1; end
      GAP:     busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  assign num   = num_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sent  = sent_q;

endmodule
